// File: rtl/display_console_writer_if.sv
// Display data/status handshake and frame-buffer write bus for the console writer.
interface display_console_writer_if #(
    parameter int unsigned COLS   = 80,
    parameter int unsigned ROWS   = 30,
    parameter int unsigned ADDR_W = 12
);
    localparam int unsigned ROW_W = $clog2(ROWS);
    localparam int unsigned COL_W = $clog2(COLS);

    logic              DDR_Load;
    logic [7:0]        DDR_Data;
    logic              DSR_Ready;
    logic              Overrun;
    logic              FB_WE;
    logic [ADDR_W-1:0] FB_Addr;
    logic [7:0]        FB_Data;
    logic [ROW_W-1:0]  Row_Offset;
    logic [ROW_W-1:0]  Cursor_Row;
    logic [COL_W-1:0]  Cursor_Col;

    modport master (
        output DDR_Load, DDR_Data,
        input  DSR_Ready, Overrun, FB_WE, FB_Addr, FB_Data, Row_Offset, Cursor_Row, Cursor_Col
    );

    modport slave (
        input  DDR_Load, DDR_Data,
        output DSR_Ready, Overrun, FB_WE, FB_Addr, FB_Data, Row_Offset, Cursor_Row, Cursor_Col
    );
endinterface

// File: rtl/display_console_writer.sv
// Character-cell console writer: cursor, control characters, circular-offset scrolling
// and row clearing into a frame buffer, with a display-ready status handshake.
module display_console_writer #(
    parameter int unsigned COLS   = 80,
    parameter int unsigned ROWS   = 30,
    parameter int unsigned ADDR_W = 12
) (
    input  logic                      Clk,
    input  logic                      Reset,
    display_console_writer_if.slave   bus
);
    localparam int unsigned ROW_W = $clog2(ROWS);
    localparam int unsigned COL_W = $clog2(COLS);
    localparam int unsigned SUM_W = ROW_W + 1;
    localparam int unsigned CNT_W = ADDR_W + 1;

    localparam logic [CNT_W-1:0] CELLS     = CNT_W'(COLS * ROWS);
    localparam logic [CNT_W-1:0] ROW_CELLS = CNT_W'(COLS);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(COLS - 1);
    localparam logic [SUM_W-1:0] ROWS_SUM  = SUM_W'(ROWS);

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_BS    = 8'h08;

    typedef enum logic [1:0] {CLR_ALL, IDLE, EXEC, CLR_ROW} state_t;

    state_t           state;
    logic [7:0]       char_q;
    logic [CNT_W-1:0] clr_cnt;

    logic [SUM_W-1:0] row_sum_c;
    logic [ROW_W-1:0] phys_row_c;
    logic             advance_c;

    function automatic logic is_print(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] prow,
                                                    input logic [COL_W-1:0] col);
        return ADDR_W'(prow) * ADDR_W'(COLS) + ADDR_W'(col);
    endfunction

    // Logical cursor row to physical row: widened sum, one conditional subtract
    always_comb begin
        row_sum_c  = {1'b0, bus.Row_Offset} + {1'b0, bus.Cursor_Row};
        phys_row_c = (row_sum_c >= ROWS_SUM) ? ROW_W'(row_sum_c - ROWS_SUM) : ROW_W'(row_sum_c);
        advance_c  = (is_print(char_q) && (bus.Cursor_Col == LAST_COL)) || (char_q == CH_LF);
    end

    // Cell writes are registered on the accepting edge so they appear during EXEC
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state          <= CLR_ALL;
            char_q         <= CH_SPACE;
            clr_cnt        <= '0;
            bus.DSR_Ready  <= 1'b0;
            bus.Overrun    <= 1'b0;
            bus.FB_WE      <= 1'b0;
            bus.FB_Addr    <= '0;
            bus.FB_Data    <= CH_SPACE;
            bus.Row_Offset <= '0;
            bus.Cursor_Row <= '0;
            bus.Cursor_Col <= '0;
        end else begin
            if (bus.DDR_Load && (state != IDLE)) begin
                bus.Overrun <= 1'b1;
            end
            case (state)
                CLR_ALL: begin
                    if (clr_cnt == CELLS) begin
                        bus.FB_WE     <= 1'b0;
                        bus.DSR_Ready <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        bus.FB_WE   <= 1'b1;
                        bus.FB_Addr <= ADDR_W'(clr_cnt);
                        bus.FB_Data <= CH_SPACE;
                        clr_cnt     <= clr_cnt + CNT_W'(1);
                    end
                end
                IDLE: begin
                    bus.FB_WE <= 1'b0;
                    if (bus.DDR_Load) begin
                        char_q        <= bus.DDR_Data;
                        bus.DSR_Ready <= 1'b0;
                        state         <= EXEC;
                        if (is_print(bus.DDR_Data)) begin
                            bus.FB_WE   <= 1'b1;
                            bus.FB_Addr <= cell_addr(phys_row_c, bus.Cursor_Col);
                            bus.FB_Data <= bus.DDR_Data;
                        end else if ((bus.DDR_Data == CH_BS) && (bus.Cursor_Col != '0)) begin
                            bus.FB_WE   <= 1'b1;
                            bus.FB_Addr <= cell_addr(phys_row_c, bus.Cursor_Col - COL_W'(1));
                            bus.FB_Data <= CH_SPACE;
                        end
                    end
                end
                EXEC: begin
                    bus.FB_WE     <= 1'b0;
                    bus.DSR_Ready <= 1'b1;
                    state         <= IDLE;
                    if (is_print(char_q)) begin
                        bus.Cursor_Col <= (bus.Cursor_Col == LAST_COL) ? '0 : bus.Cursor_Col + COL_W'(1);
                    end else if ((char_q == CH_LF) || (char_q == CH_CR)) begin
                        bus.Cursor_Col <= '0;
                    end else if ((char_q == CH_BS) && (bus.Cursor_Col != '0)) begin
                        bus.Cursor_Col <= bus.Cursor_Col - COL_W'(1);
                    end
                    if (advance_c) begin
                        if (bus.Cursor_Row != LAST_ROW) begin
                            bus.Cursor_Row <= bus.Cursor_Row + ROW_W'(1);
                        end else begin
                            // Old top row becomes the new bottom row; start clearing it now
                            bus.Row_Offset <= (bus.Row_Offset == LAST_ROW) ? '0 : bus.Row_Offset + ROW_W'(1);
                            bus.DSR_Ready  <= 1'b0;
                            bus.FB_WE      <= 1'b1;
                            bus.FB_Addr    <= cell_addr(bus.Row_Offset, COL_W'(0));
                            bus.FB_Data    <= CH_SPACE;
                            clr_cnt        <= CNT_W'(1);
                            state          <= CLR_ROW;
                        end
                    end
                end
                CLR_ROW: begin
                    if (clr_cnt == ROW_CELLS) begin
                        bus.FB_WE     <= 1'b0;
                        bus.DSR_Ready <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        bus.FB_Addr <= bus.FB_Addr + ADDR_W'(1);
                        clr_cnt     <= clr_cnt + CNT_W'(1);
                    end
                end
                default: state <= CLR_ALL;
            endcase
        end
    end
endmodule
